// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
// The DIV_TIMEOUT_EN build uses timeoutLimit() to size the BUSY watchdog.
package div_sched_pkg;

   typedef enum logic [2:0] {IDLE, CLR, GO, BUSY, RESP} divSchedState_t;

   localparam int TIMEOUT_MUL = 4;
   localparam int TIMEOUT_ADD = 8;

   function automatic int timeoutLimit(input int width);
      return TIMEOUT_MUL * width + TIMEOUT_ADD;
   endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr_i, wrapping modulo NREQ.
// Purely combinational; gnt_o is one-hot or zero.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            vld_o
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(ptr_i) + k) % NREQ);
         if (!vld_o && req_i[cand]) begin
            vld_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_scheduler.sv
// Shares one integer divider among NREQ requesters (round-robin, one op in flight).
// Optional DIV_TIMEOUT_EN: BUSY watchdog that forces an all-ones quotient and flags respTimeout.
module div_scheduler
   import div_sched_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       reqValid,
   output logic [NREQ-1:0]       reqReady,
   input  logic [NREQ*WIDTH-1:0] reqDividend,
   input  logic [NREQ*WIDTH-1:0] reqDivisor,
   output logic [NREQ-1:0]       respValid,
   input  logic [NREQ-1:0]       respReady,
   output logic [WIDTH-1:0]      respQuot,
   output logic                  respDivZero,
`ifdef DIV_TIMEOUT_EN
   output logic                  respTimeout,
`endif
   output logic [WIDTH-1:0]      divIn1,
   output logic [WIDTH-1:0]      divIn2,
   output logic                  divStart,
   output logic                  divReset,
   input  logic [WIDTH-1:0]      divOut,
   input  logic                  divDone
);

   localparam int IW = $clog2(NREQ);

   divSchedState_t   state_q, state_d;
   logic [IW-1:0]    rrPtr_q, rrPtr_d;
   logic [IW-1:0]    grant_q, grant_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic             divZero_q, divZero_d;
`ifdef DIV_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(timeoutLimit(WIDTH));
   logic             timeout_q, timeout_d;
   logic [7:0]       wdog_q, wdog_d;
`endif

   logic [NREQ-1:0]  arbGnt;
   logic [IW-1:0]    arbIdx;
   logic             arbVld;
   logic [NREQ-1:0]  respOne;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (reqValid),
      .ptr_i (rrPtr_q),
      .gnt_o (arbGnt),
      .idx_o (arbIdx),
      .vld_o (arbVld)
   );

   assign respOne     = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
   assign respQuot    = (state_q == RESP) ? quot_q : '0;
   assign respDivZero = divZero_q;
`ifdef DIV_TIMEOUT_EN
   assign respTimeout = timeout_q;
`endif

   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      grant_d   = grant_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      quot_d    = quot_q;
      divZero_d = divZero_q;
`ifdef DIV_TIMEOUT_EN
      timeout_d = timeout_q;
      wdog_d    = wdog_q;
`endif
      reqReady  = '0;
      respValid = '0;
      divStart  = 1'b0;
      divReset  = 1'b0;
      divIn1    = '0;
      divIn2    = '0;
      unique case (state_q)
         IDLE: begin
            // reqReady is combinational, so keep it quiet while reset is held
            if (arbVld && reset_n) begin
               reqReady = arbGnt;
               grant_d  = arbIdx;
               dvd_d    = reqDividend[arbIdx*WIDTH +: WIDTH];
               dvs_d    = reqDivisor[arbIdx*WIDTH +: WIDTH];
               if (dvs_d == '0) begin
                  quot_d    = '1;
                  divZero_d = 1'b1;
                  state_d   = RESP;
               end else begin
                  state_d   = CLR;
               end
            end
         end
         CLR: begin
            divReset = 1'b1;
            divIn1   = dvd_q;
            divIn2   = dvs_q;
            state_d  = GO;
         end
         GO: begin
            divStart = 1'b1;
            divIn1   = dvd_q;
            divIn2   = dvs_q;
`ifdef DIV_TIMEOUT_EN
            wdog_d   = '0;
`endif
            state_d  = BUSY;
         end
         BUSY: begin
            divIn1 = dvd_q;
            divIn2 = dvs_q;
            if (divDone) begin
               quot_d  = divOut;
               state_d = RESP;
            end
`ifdef DIV_TIMEOUT_EN
            else if (wdog_q == TO_LIM - 8'd1) begin
               quot_d    = '1;
               timeout_d = 1'b1;
               divReset  = 1'b1;
               state_d   = RESP;
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
`endif
         end
         RESP: begin
            respValid = respOne;
            if (respReady[grant_q]) begin
               rrPtr_d   = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + IW'(1);
               divZero_d = 1'b0;
`ifdef DIV_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rrPtr_q   <= '0;
         grant_q   <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         quot_q    <= '0;
         divZero_q <= 1'b0;
`ifdef DIV_TIMEOUT_EN
         timeout_q <= 1'b0;
         wdog_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         grant_q   <= grant_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         quot_q    <= quot_d;
         divZero_q <= divZero_d;
`ifdef DIV_TIMEOUT_EN
         timeout_q <= timeout_d;
         wdog_q    <= wdog_d;
`endif
      end
   end

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: scoreboard of expected responses filled on accept,
// checked on response; includes a small latency-3 divider model.
module tb_div_scheduler;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic                  clock = 1'b0;
   logic                  reset_n = 1'b0;
   logic [NREQ-1:0]       reqValid = '0;
   logic [NREQ-1:0]       reqReady;
   logic [NREQ*WIDTH-1:0] reqDividend = '0;
   logic [NREQ*WIDTH-1:0] reqDivisor = '0;
   logic [NREQ-1:0]       respValid;
   logic [NREQ-1:0]       respReady = '1;
   logic [WIDTH-1:0]      respQuot;
   logic                  respDivZero;
`ifdef DIV_TIMEOUT_EN
   logic                  respTimeout;
`endif
   logic [WIDTH-1:0]      divIn1, divIn2, divOut;
   logic                  divStart, divReset, divDone;

   div_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clock(clock), .reset_n(reset_n),
      .reqValid(reqValid), .reqReady(reqReady),
      .reqDividend(reqDividend), .reqDivisor(reqDivisor),
      .respValid(respValid), .respReady(respReady),
      .respQuot(respQuot), .respDivZero(respDivZero),
`ifdef DIV_TIMEOUT_EN
      .respTimeout(respTimeout),
`endif
      .divIn1(divIn1), .divIn2(divIn2), .divStart(divStart), .divReset(divReset),
      .divOut(divOut), .divDone(divDone)
   );

   always #5 clock = ~clock;

   // divider model: done 3 edges after the start edge, unless hang is set
   bit               hang = 1'b0;
   int               m_cnt;
   logic [WIDTH-1:0] m_a, m_b;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt <= 0; divDone <= 1'b0; divOut <= '0; m_a <= '0; m_b <= '0;
      end else begin
         divDone <= 1'b0;
         if (divReset) m_cnt <= 0;
         else if (divStart) begin
            m_a <= divIn1; m_b <= divIn2; m_cnt <= 3;
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !hang) begin
               divDone <= 1'b1;
               divOut  <= (m_b == 0) ? '1 : m_a / m_b;
            end
         end
      end
   end

   int cyc = 0, n_start = 0, n_reset = 0;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      if (divStart) n_start <= n_start + 1;
      if (divReset) n_reset <= n_reset + 1;
   end

   typedef struct {int idx; logic [WIDTH-1:0] q; logic dz; logic to;} exp_t;
   exp_t             sb[$];
   int               gnt_log[$];
   logic [WIDTH-1:0] opA[NREQ], opB[NREQ];
   int               total = 0, bad = 0, acc_cyc = 0, bp_hold = 0, lat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input int i, input int a, input int b);
      opA[i] = a[WIDTH-1:0];
      opB[i] = b[WIDTH-1:0];
      reqDividend[i*WIDTH +: WIDTH] = a[WIDTH-1:0];
      reqDivisor[i*WIDTH +: WIDTH]  = b[WIDTH-1:0];
      reqValid[i] = 1'b1;
   endtask

   // service accepts and responses until nothing is pending; lat = accept-to-response cycles
   task automatic run(input int maxc, output int lt);
      int acc, idx, rel;
      bit ok;
      exp_t e;
      ok = 1'b0;
      lt = -1;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clock);
         acc = -1;
         rel = -1;
         for (int i = 0; i < NREQ; i++) if (reqReady[i]) acc = i;
         if (acc >= 0) begin
            e.idx = acc;
            e.dz  = (opB[acc] == 0);
            e.q   = e.dz ? '1 : (hang ? '1 : opA[acc] / opB[acc]);
            e.to  = hang && !e.dz;
            sb.push_back(e);
            gnt_log.push_back(acc);
            acc_cyc = cyc;
         end
         if (respValid != 0) begin
            chk("req_during_resp", reqReady, 0);
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (respValid[i]) idx = i;
            if (sb.size() == 0) chk("resp_unexpected", respValid, 0);
            else begin
               e = sb[0];
               chk("resp_onehot", respValid, 32'(1) << e.idx);
               chk("resp_quot", respQuot, e.q);
               chk("resp_divzero", respDivZero, e.dz);
`ifdef DIV_TIMEOUT_EN
               chk("resp_timeout", respTimeout, e.to);
`endif
               if (respReady[idx]) begin
                  void'(sb.pop_front());
                  lt = cyc - acc_cyc;
               end else if (bp_hold > 0) begin
                  bp_hold--;
                  if (bp_hold == 0) rel = idx;
               end
            end
         end
         @(posedge clock);
         #1;
         if (acc >= 0) reqValid[acc] = 1'b0;
         if (rel >= 0) respReady[rel] = 1'b1;
         if (reqValid == 0 && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("run_completed", ok, 1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_reqReady"}, reqReady, 0);
      chk({tag, "_respValid"}, respValid, 0);
      chk({tag, "_respQuot"}, respQuot, 0);
      chk({tag, "_respDivZero"}, respDivZero, 0);
      chk({tag, "_divIn1"}, divIn1, 0);
      chk({tag, "_divIn2"}, divIn2, 0);
      chk({tag, "_divStart"}, divStart, 0);
      chk({tag, "_divReset"}, divReset, 0);
   endtask

   initial begin
      int w;
      bit seen;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_idle_outputs("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // all four at once: fairness from rrPtr=0
      gnt_log.delete();
      drive_req(0, 100, 10); drive_req(1, 50, 5); drive_req(2, 9, 3); drive_req(3, 255, 1);
      run(300, lat);
      chk("fair_count", gnt_log.size(), 4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i);
      chk("idle_divIn1", divIn1, 0);

      // single op, latency = accept + CLR + GO + 3 divider + capture
      n_start = 0; n_reset = 0;
      drive_req(0, 200, 7);
      run(100, lat);
      chk("single_latency", lat, 7);
      chk("single_starts", n_start, 1);
      chk("single_clears", n_reset, 1);

      // backpressure on requester 1 while requester 3 waits
      respReady[1] = 1'b0;
      bp_hold = 5;
      gnt_log.delete();
      drive_req(1, 77, 7);
      drive_req(3, 90, 9);
      run(200, lat);
      chk("bp_first_grant", gnt_log[0], 1);
      chk("bp_second_grant", gnt_log[1], 3);
      respReady = '1;

      // divide by zero never touches the divider
      n_start = 0; n_reset = 0;
      drive_req(2, 37, 0);
      run(50, lat);
      chk("dz_latency", lat, 1);
      chk("dz_starts", n_start, 0);
      chk("dz_clears", n_reset, 0);

      // reset in BUSY (rrPtr is 3 beforehand)
      drive_req(1, 90, 9);
      seen = 1'b0;
      for (w = 0; w < 20 && !seen; w++) begin
         @(negedge clock);
         seen = reqReady[1];
      end
      chk("rst_accept_seen", seen, 1);
      @(posedge clock); #1;
      reqValid[1] = 1'b0;
      seen = 1'b0;
      for (w = 0; w < 20 && !seen; w++) begin
         @(negedge clock);
         seen = divStart;
      end
      chk("rst_start_seen", seen, 1);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      sb.delete();
      gnt_log.delete();
      drive_req(0, 40, 8);
      drive_req(3, 60, 6);
      run(200, lat);
      chk("postrst_first_grant", gnt_log[0], 0);

`ifdef DIV_TIMEOUT_EN
      hang = 1'b1;
      n_start = 0; n_reset = 0;
      drive_req(2, 50, 3);
      run(200, lat);
      chk("to_latency", lat, 43);
      chk("to_clears", n_reset, 2);
      chk("to_starts", n_start, 1);
      hang = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
